// File: rtl/counter_ctrl_fsm.sv
// counter_ctrl_fsm: interval-timer controller for an external 32-bit up/down
// counter. It loads the counter with the interval, watches the counter's
// registered terminal-count flag and raises a sticky irq on each expiry.
// In one-shot mode the timer returns to idle; in periodic mode it reloads.
// Optional feature macro: COUNTER_CTRL_WRAPCNT_EN. When defined, wrap_cnt
// counts expiries since reset. When undefined, wrap_cnt is tied to zero.
module counter_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic        dir,
  input  logic [31:0] period,
  input  logic [31:0] cnt,
  input  logic        Rc,
  input  logic        irq_ack,
  output logic        Load,
  output logic        s,
  output logic [31:0] PData,
  output logic        irq,
  output logic        busy,
  output logic [15:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        mode_l;
  logic        dir_l;
  logic        first_run;

  logic        load_nxt;
  logic        s_nxt;
  logic        busy_nxt;
  logic [31:0] pdata_nxt;

  logic        go;
  logic        expiry;
  logic        dir_sel;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b0;
    s_nxt     = s;
    busy_nxt  = 1'b0;
    pdata_nxt = PData;

    // stop beats start in idle; start is ignored everywhere else
    go      = (state == IDLE) && start && !stop;
    // Rc is stale during the first RUN cycle because the counter held it over Load
    expiry  = (state == RUN) && !first_run && Rc && !stop;
    // a fresh start uses the live dir input; a periodic reload uses the latched one
    dir_sel = (state == IDLE) ? dir : dir_l;

    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (expiry) begin
          state_nxt = mode_l ? LOAD : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    case (state_nxt)
      IDLE: begin
        load_nxt = 1'b1;
        busy_nxt = 1'b0;
        // Capture cnt only when leaving LOAD/RUN. While idle the counter keeps
        // reloading this value, so holding it freezes the count. Re-sampling
        // cnt every idle cycle would chase the counter's last step and oscillate.
        if (state != IDLE) begin
          pdata_nxt = cnt;
        end
      end
      LOAD: begin
        load_nxt  = 1'b1;
        busy_nxt  = 1'b1;
        s_nxt     = dir_sel;
        // An up-count from ~P reaches all-ones after exactly P steps, mirroring a down-count from P to 0
        pdata_nxt = dir_sel ? ~period : period;
      end
      RUN: begin
        load_nxt = 1'b0;
        busy_nxt = 1'b1;
      end
      default: begin
        load_nxt = 1'b1;
      end
    endcase
  end

  // State register, registered Moore outputs, and the mode/dir latched at start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      Load      <= 1'b1;
      s         <= 1'b0;
      PData     <= 32'd0;
      busy      <= 1'b0;
      mode_l    <= 1'b0;
      dir_l     <= 1'b0;
      first_run <= 1'b0;
    end else begin
      state     <= state_nxt;
      Load      <= load_nxt;
      s         <= s_nxt;
      PData     <= pdata_nxt;
      busy      <= busy_nxt;
      first_run <= (state_nxt == RUN) && (state != RUN);
      if (go) begin
        mode_l <= mode;
        dir_l  <= dir;
      end
    end
  end

  // Sticky expiry flag; a coincident expiry wins over irq_ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (expiry) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

`ifdef COUNTER_CTRL_WRAPCNT_EN
  logic [15:0] wrap_q;

  // Expiry counter, wrapping modulo 2^16.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q <= 16'd0;
    end else if (expiry) begin
      wrap_q <= wrap_q + 16'd1;
    end
  end

  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_counter_ctrl_fsm.sv
// tb_counter_ctrl_fsm: directed and randomized bench for counter_ctrl_fsm.
// An external up/down counter model is attached to the DUT. The reference
// model predicts outputs from the interval schedule: a LOAD at cycle T with
// interval P expires at cycle T+P+2. The bench honours COUNTER_CTRL_WRAPCNT_EN.
module tb_counter_ctrl_fsm;

`ifdef COUNTER_CTRL_WRAPCNT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        mode;
  logic        dir;
  logic [31:0] period;
  logic [31:0] cnt;
  logic        Rc;
  logic        irq_ack;
  logic        Load;
  logic        s;
  logic [31:0] PData;
  logic        irq;
  logic        busy;
  logic [15:0] wrap_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  longint      n       = 0;
  longint      m_t     = -100;
  longint      m_p     = 0;
  bit          m_busy  = 1'b0;
  bit          m_mode  = 1'b0;
  bit          m_dir   = 1'b0;
  bit          m_s     = 1'b0;
  bit          m_irq   = 1'b0;
  logic [31:0] m_pdata = 32'd0;
  int          m_wrap  = 0;
  int          m_idle  = 0;

  counter_ctrl_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .dir      (dir),
    .period   (period),
    .cnt      (cnt),
    .Rc       (Rc),
    .irq_ack  (irq_ack),
    .Load     (Load),
    .s        (s),
    .PData    (PData),
    .irq      (irq),
    .busy     (busy),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  // External counter: loads on Load (holding Rc), otherwise steps and registers terminal count
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 32'd0;
      Rc  <= 1'b1;
    end else if (Load) begin
      cnt <= PData;
    end else begin
      cnt <= s ? cnt + 32'd1 : cnt - 32'd1;
      Rc  <= s ? (cnt == 32'hFFFFFFFF) : (cnt == 32'd0);
    end
  end

  function automatic logic [63:0] expWrap(input int w);
    return WRAP_EN ? 64'(w & 32'h0000FFFF) : 64'd0;
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic sp, input logic md,
                               input logic dr, input logic ak, input logic [31:0] per);
    rst_n   = r;
    start   = st;
    stop    = sp;
    mode    = md;
    dir     = dr;
    irq_ack = ak;
    period  = per;
  endtask

  // advance one clock and update the schedule model from the inputs seen at that edge
  task automatic tick();
    logic        r, st, sp, md, dr, ak;
    logic [31:0] per, cb;
    longint      prev;
    bit          ex;
    r = rst_n; st = start; sp = stop; md = mode; dr = dir; ak = irq_ack;
    per = period; cb = cnt; prev = n;
    @(posedge clk);
    #1;
    n = n + 1;
    if (!r) begin
      m_busy = 1'b0; m_s = 1'b0; m_pdata = 32'd0; m_irq = 1'b0;
      m_wrap = 0; m_t = -100; m_idle = 0;
    end else if (!m_busy) begin
      if (ak) m_irq = 1'b0;
      if (st && !sp) begin
        m_busy = 1'b1; m_t = n; m_p = longint'({32'd0, per});
        m_dir = dr; m_mode = md; m_s = dr;
        m_pdata = dr ? ~per : per;
      end else begin
        m_idle++;
      end
    end else begin
      ex = !sp && (prev == m_t + m_p + 2);
      if (ex) begin
        m_irq  = 1'b1;
        m_wrap = (m_wrap + 1) % 65536;
      end else if (ak) begin
        m_irq = 1'b0;
      end
      if (sp || (ex && !m_mode)) begin
        m_busy = 1'b0; m_pdata = cb; m_idle = 0;
      end else if (ex) begin
        m_t = n; m_p = longint'({32'd0, per});
        m_pdata = m_dir ? ~per : per;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".Load"},  64'(Load),     64'(!m_busy || (n == m_t)));
    checkValue({tag, ".s"},     64'(s),        64'(m_s));
    checkValue({tag, ".PData"}, 64'(PData),    64'(m_pdata));
    checkValue({tag, ".busy"},  64'(busy),     64'(m_busy));
    checkValue({tag, ".irq"},   64'(irq),      64'(m_irq));
    checkValue({tag, ".wrap"},  64'(wrap_cnt), expWrap(m_wrap));
    if (!m_busy && m_idle >= 1)
      checkValue({tag, ".frozen_cnt"}, 64'(cnt), 64'(m_pdata));
  endtask

  task automatic cycle(input string tag);
    tick();
    checkOutput(tag);
  endtask

  initial begin
    longint      t0;
    longint      rc_n;
    longint      irq_n;
    int          loads;
    int          w0;
    logic        r, st, sp, md, dr, ak;
    logic [31:0] per;

    $display("[TB] start");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    cycle("reset");
    cycle("reset");

    // stale Rc held after reset, down one-shot P=10: expiry 12 cycles after LOAD
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10);
    cycle("a_idle");
    checkValue("a_stale_rc", 64'(Rc), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10);
    cycle("a_start");
    t0 = n;
    irq_n = -1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10);
    for (int i = 0; i < 20; i++) begin
      cycle("a_run");
      if (irq === 1'b1 && irq_n < 0) irq_n = n;
    end
    checkValue("a_irq_delay", 64'(irq_n - t0), 64'd13);
    checkValue("a_idle_busy", 64'(busy), 64'd0);

    // reset, then down periodic P=5: LOAD every 8 cycles, irq one cycle after Rc
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5);
    cycle("b_reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5);
    cycle("b_start");
    t0 = n; rc_n = -1; irq_n = -1; loads = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    for (int i = 0; i < 24; i++) begin
      cycle("b_run");
      if (n >= t0 + 2 && Rc === 1'b1 && rc_n < 0) rc_n = n;
      if (irq === 1'b1 && irq_n < 0) irq_n = n;
      if (Load === 1'b1) loads++;
    end
    checkValue("b_loads", 64'(loads), 64'd3);
    checkValue("b_irq_after_rc", 64'(irq_n - rc_n), 64'd1);
    checkValue("b_load_at_24", 64'(Load), 64'd1);
    checkValue("b_wrap", 64'(wrap_cnt), expWrap(3));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd5);
    cycle("b_stop");

    // up one-shot P=2: PData=~2 in LOAD, one expiry, frozen idle, irq until ack
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
    cycle("c_start");
    checkValue("c_pdata_load", 64'(PData), 64'hFFFFFFFD);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
    for (int i = 0; i < 7; i++) cycle("c_run");
    checkValue("c_busy", 64'(busy), 64'd0);
    checkValue("c_irq", 64'(irq), 64'd1);
    checkValue("c_cnt_frozen", 64'(cnt), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2);
    cycle("c_ack");
    checkValue("c_irq_cleared", 64'(irq), 64'd0);

    // stop coincident with Rc=1: no irq, no wrap change
    w0 = m_wrap;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
    cycle("d_start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
    for (int i = 0; i < 5; i++) cycle("d_run");
    checkValue("d_rc_high", 64'(Rc), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
    cycle("d_stop");
    checkValue("d_busy", 64'(busy), 64'd0);
    checkValue("d_irq", 64'(irq), 64'd0);
    checkValue("d_wrap", 64'(wrap_cnt), expWrap(w0));

    // periodic P=0: ack alone clears irq, ack with expiry leaves irq set
    w0 = m_wrap;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle("e_start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle("e_run");
    cycle("e_run");
    cycle("e_reload");
    checkValue("e_irq_set", 64'(irq), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    cycle("e_ack");
    checkValue("e_irq_acked", 64'(irq), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle("e_run");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    cycle("e_ack_expiry");
    checkValue("e_irq_kept", 64'(irq), 64'd1);
    checkValue("e_wrap", 64'(wrap_cnt), expWrap(w0 + 2));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle("e_stop");

    // reset on the pending-expiry cycle of an up periodic run
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4);
    cycle("f_start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4);
    for (int i = 0; i < 6; i++) cycle("f_run");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4);
    cycle("f_reset");
    checkValue("f_load", 64'(Load), 64'd1);
    checkValue("f_pdata", 64'(PData), 64'd0);
    checkValue("f_s", 64'(s), 64'd0);
    checkValue("f_irq", 64'(irq), 64'd0);
    checkValue("f_busy", 64'(busy), 64'd0);
    checkValue("f_wrap", 64'(wrap_cnt), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4);
    cycle("f_post");
    checkValue("f_post_idle", 64'(busy), 64'd0);

    // randomized traffic against the schedule model
    for (int i = 0; i < 700; i++) begin
      r  = ($urandom_range(0, 79) != 0);
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 19) == 0);
      ak = ($urandom_range(0, 3) == 0);
      md = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       per = 32'hFFFFFFFF;
        1:       per = $urandom();
        default: per = 32'($urandom_range(0, 6));
      endcase
      applyStimulus(r, st, sp, md, dr, ak, per);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_ctrl_fsm.md
COUNTER_CTRL_FSM -- requirements
Module: counter_ctrl_fsm

Interface
REQ-001 clk  input  1  rising-edge clock; SHALL clock every register.
REQ-002 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-003 start  input  1  begin timing when idle (level-sampled each edge).
REQ-004 stop  input  1  abort timing and return to idle.
REQ-005 mode  input  1  0 = one-shot, 1 = periodic; sampled at start.
REQ-006 dir  input  1  0 = down-count, 1 = up-count; sampled at start.
REQ-007 period  input  32  interval value P; sampled at start and at each periodic reload.
REQ-008 cnt  input  32  current value from the external 32-bit up/down counter.
REQ-009 Rc  input  1  registered terminal-count flag from the external counter.
REQ-010 irq_ack  input  1  clears irq.
REQ-011 Load  output  1  load strobe to the counter.
REQ-012 s  output  1  count direction to the counter (1 = up).
REQ-013 PData  output  32  load value to the counter.
REQ-014 irq  output  1  sticky expiry flag.
REQ-015 busy  output  1  high in LOAD and RUN.
REQ-016 wrap_cnt  output  16  count of expiries since reset.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN, with Load, s, PData and busy as registered Moore outputs.
REQ-018 IDLE: Load=1 and PData=cnt, freezing the counter; s holds its last value.
REQ-019 IDLE with start=1 and stop=0: latch mode/dir, go to LOAD; start while in LOAD/RUN SHALL be ignored.
REQ-020 LOAD (one cycle): Load=1, s=dir_latched, PData=P when down, ~P when up; then go to RUN.
REQ-021 RUN: Load=0; Rc SHALL be ignored in the first RUN cycle (stale, held during Load).
REQ-022 From the second RUN cycle, Rc=1 means expiry: set irq; increment wrap_cnt (mod 2^16).
REQ-023 On expiry: periodic mode goes to LOAD, re-sampling period; one-shot mode goes to IDLE.
REQ-024 Periodic interval SHALL be exactly P+3 cycles between successive LOAD cycles, for both dir values and for P=0 (3 cycles).
REQ-025 stop=1 in LOAD or RUN: go to IDLE next edge, with no irq and no wrap_cnt change, even if Rc=1 in the same cycle.
REQ-026 start and stop both high in IDLE: stop wins and the FSM remains IDLE.
REQ-027 irq: set on expiry, cleared on irq_ack; simultaneous expiry and irq_ack SHALL leave irq=1.
REQ-028 P=32'hFFFFFFFF SHALL work without special casing.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE with Load=1, PData=0, s=0, irq=0, busy=0 and wrap_cnt=0, overriding all other inputs.
REQ-030 Reset mid-RUN SHALL discard the pending expiry; the first post-reset cycle is IDLE.

Configuration
REQ-031 Macro COUNTER_CTRL_WRAPCNT_EN defined: wrap_cnt SHALL behave per REQ-022.
REQ-032 Macro COUNTER_CTRL_WRAPCNT_EN undefined: wrap_cnt SHALL be constant 0 with no counter register; all other behaviour is unchanged.

Verification
REQ-033 Down, periodic, P=5, with a counter model attached -> Load pulses every 8 cycles; irq rises 1 cycle after Rc; wrap_cnt=3 after 3 intervals.
REQ-034 Up, one-shot, P=2 -> PData=32'hFFFFFFFD in LOAD; one expiry; return to IDLE with cnt frozen; busy=0; irq=1 until irq_ack.
REQ-035 Stale Rc=1 held before start, P=10 -> no expiry in the first RUN cycle; the first expiry occurs 12 cycles after LOAD.
REQ-036 stop asserted in the same cycle as Rc=1 -> IDLE; irq=0; wrap_cnt unchanged.
REQ-037 irq_ack coincident with a periodic expiry (P=0) -> irq stays 1; wrap_cnt increments.
REQ-038 rst_n=0 for 1 cycle mid-RUN, then both macro settings exercised -> all outputs at reset values; wrap_cnt is always 0 when COUNTER_CTRL_WRAPCNT_EN is undefined.
